// File: rtl/aes_key_sched_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_pkg : shared constants, FSM encoding, S-box and xtime for AES-128     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Entry 0 sits in the top byte, so byte b lives at bit offset (255-b)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_sched_ctrl_round_step.sv
// +--------------------------------------------------------------------------+
// | aes_key_round_step : one combinational AES-128 key-expansion round       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prev_key_i,
  input  logic [7:0]       rcon_i,
  output logic [KEY_W-1:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key_i;

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  // Rcon lands on the most significant byte only.
  assign t   = sub ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
// +--------------------------------------------------------------------------+
// | aes_key_sched_ctrl : AES-128 key-schedule controller, one round key per  |
// | valid/ready handshake. Optional round-key store: AES_KEY_STORE_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] round_key_q, round_key_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [KEY_W-1:0] next_key;
  logic             handshake;

  aes_key_round_step u_step (
    .prev_key_i (round_key_q),
    .rcon_i     (rcon_q),
    .next_key_o (next_key)
  );

  assign handshake = (state_q == ST_EMIT) && rk_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    idx_d       = idx_q;
    rcon_d      = rcon_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_EMIT;
          round_key_d = key_in;
          idx_d       = 4'd0;
          rcon_d      = RCON_INIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            round_key_d = next_key;
            idx_d       = idx_q + 4'd1;
            rcon_d      = xtime(rcon_q);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_key_q <= '0;
      idx_q       <= 4'd0;
      rcon_q      <= RCON_INIT;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      idx_q       <= idx_d;
      rcon_q      <= rcon_d;
    end
  end

  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q == ST_EMIT);
  assign done      = (state_q == ST_FINISH);
  assign round_key = round_key_q;
  assign round_idx = idx_q;

`ifdef AES_KEY_STORE_EN
  // Cleared on reset so never-written entries read back as zero.
  logic [KEY_W-1:0] store_q [0:NUM_ROUNDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        store_q[i] <= '0;
      end
    end else if (handshake) begin
      store_q[idx_q] <= round_key_q;
    end
  end

  assign rd_key = (rd_idx <= LAST_IDX) ? store_q[rd_idx] : '0;
`else
  logic unused_rd_idx;
  logic unused_handshake;

  assign unused_rd_idx    = ^rd_idx;
  assign unused_handshake = handshake;
  assign rd_key           = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_aes_key_sched_ctrl : scoreboard bench for the AES-128 key scheduler   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_sched_ctrl;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [127:0] key_in   = '0;
  logic         rk_ready = 1'b0;
  logic [3:0]   rd_idx   = 4'd0;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] rd_key;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] ZERO_RK [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  localparam logic [7:0] RCON_EXP [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   passes   = 0;
  bit   done_due = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: compares every presented round key against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_due) begin
        chk("done_pulse", 128'(done), 128'd1);
        chk("valid_after_last", 128'(rk_valid), 128'd0);
        chk("busy_after_last", 128'(busy), 128'd0);
        done_due = 1'b0;
      end else if (done) begin
        checks++;
        $display("FAIL done_spurious: got done=1, expected 0");
      end
      if (rk_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got idx %0d, expected no key", round_idx);
        end else begin
          chk("round_key", round_key, sb[0].key);
          chk("round_idx", 128'(round_idx), 128'(sb[0].idx));
          chk("busy_in_emit", 128'(busy), 128'd1);
          if (rk_ready) begin
            if (sb[0].idx < 4'd10) chk("rcon", 128'(dut.rcon_q), 128'(RCON_EXP[sb[0].idx]));
            if (sb[0].idx == 4'd10) done_due = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run_key(input logic [127:0] key, input int sel, input bit rnd,
                         input int inj_idx, input int rst_idx);
    exp_t e;
    int   vcnt;
    bit   finished;
    bit   aborted;
    bit   injected;
    for (int i = 0; i <= 10; i++) begin
      e.idx = 4'(i);
      e.key = (sel == 0) ? FIPS_RK[i] : ZERO_RK[i];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start    = 1'b1;
    key_in   = key;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    key_in   = ~key;
    vcnt     = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    injected = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      start = 1'b0;
      if (rk_valid) vcnt++;
      if (done) begin
        start    = 1'b1;
        key_in   = 128'h00112233445566778899aabbccddeeff;
        finished = 1'b1;
      end else if (rk_valid && int'(round_idx) == rst_idx) begin
        rst_n    = 1'b0;
        rk_ready = 1'b0;
        finished = 1'b1;
        aborted  = 1'b1;
      end else begin
        if (rk_valid && int'(round_idx) == inj_idx && !injected) begin
          start    = 1'b1;
          key_in   = 128'hffeeddccbbaa99887766554433221100;
          injected = 1'b1;
        end
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      $display("FAIL run_timeout: got no done within 300 cycles, expected done");
      sb.delete();
    end else if (aborted) begin
      sb.delete();
      done_due = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 128'(rk_valid), 128'd0);
      chk("rst_mid_busy", 128'(busy), 128'd0);
      chk("rst_mid_done", 128'(done), 128'd0);
      chk("rst_mid_idx", 128'(round_idx), 128'd0);
      chk("rst_mid_key", round_key, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("no_done_after_rst", 128'(done), 128'd0);
      chk("idle_after_rst", 128'(rk_valid), 128'd0);
    end else begin
      if (!rnd) chk("valid_cycles", 128'(vcnt), 128'd11);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("finish_start_ignored_valid", 128'(rk_valid), 128'd0);
      chk("finish_start_ignored_busy", 128'(busy), 128'd0);
      chk("queue_drained", 128'(sb.size()), 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_idx", 128'(round_idx), 128'd0);
    chk("rst_key", round_key, 128'd0);
    chk("rst_rcon", 128'(dut.rcon_q), 128'h01);
    chk("rst_rd_key", rd_key, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 key, continuous ready, stray start at idx 4 and during FINISH.
    run_key(FIPS_KEY, 0, 1'b0, 4, 99);

`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd1;  #1; chk("store_idx1", rd_key, FIPS_RK[1]);
    rd_idx = 4'd10; #1; chk("store_idx10", rd_key, FIPS_RK[10]);
    rd_idx = 4'd0;  #1; chk("store_idx0", rd_key, FIPS_RK[0]);
    rd_idx = 4'd15; #1; chk("store_idx15", rd_key, 128'd0);
`else
    rd_idx = 4'd1;  #1; chk("nostore_idx1", rd_key, 128'd0);
    rd_idx = 4'd10; #1; chk("nostore_idx10", rd_key, 128'd0);
    rd_idx = 4'd15; #1; chk("nostore_idx15", rd_key, 128'd0);
`endif

    // All-zero key with pseudo-random back-pressure.
    run_key(128'd0, 1, 1'b1, 99, 99);

    // Reset asserted while round key 6 is presented.
    run_key(FIPS_KEY, 0, 1'b0, 99, 6);

    rd_idx = 4'd1; #1; chk("rd_key_after_rst", rd_key, 128'd0);

    // Recovery: a full FIPS expansion with random back-pressure after reset.
    run_key(FIPS_KEY, 0, 1'b1, 99, 99);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequential AES-128 key-schedule controller. Drives the per-round SubWord/RotWord/Rcon transform and the Rcon sequence that feeds it.
- Expands one 128-bit cipher key into round keys 0..10 and emits one round key per valid/ready handshake to the round datapath.
- Sits between the key-load interface and the cipher round engine. Its Rcon sequencing replaces per-round external Rcon lookup.

Parameters:
- NUM_ROUNDS, 10, last round index emitted; fixed for AES-128 and exposed for the bench only.
- KEY_W, 128, key and round-key width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin expansion of key_in; sampled only in IDLE.
- key_in  in  KEY_W  cipher key, big-endian words w0..w3 (w0 = [127:96]); captured on an accepted start.
- rk_valid  out  1  round_key/round_idx are valid.
- rk_ready  in  1  consumer accepts the current round key.
- round_key  out  KEY_W  current round key.
- round_idx  out  4  index of round_key, 0..NUM_ROUNDS.
- busy  out  1  high from the accepted start until the last key is accepted.
- done  out  1  one-cycle pulse after round key 10 is accepted.
- rd_idx  in  4  stored-key read index (KEY_STORE_EN only).
- rd_key  out  KEY_W  stored key at rd_idx (KEY_STORE_EN only).

Behaviour:
- Reset (rst_n low at a clk edge; overrides everything, including mid-expansion): state IDLE, rk_valid 0, round_key 0, round_idx 0, busy 0, done 0, internal rcon 8'h01, rd_key 0.
- FSM states: IDLE, EMIT, FINISH.
- IDLE -> EMIT on start. Next cycle: rk_valid=1, round_key=key_in, round_idx=0, busy=1, rcon=8'h01.
- EMIT, rk_valid & rk_ready, round_idx<10: next cycle round_key = next(round_key), round_idx+1, rcon <= xtime(rcon).
- EMIT, rk_ready low: all outputs hold stable; rk_valid is never withdrawn.
- EMIT, handshake at round_idx==10 -> FINISH: rk_valid=0, busy=0, done=1 for exactly one cycle.
- FINISH -> IDLE unconditionally. A start asserted during FINISH is ignored.
- With continuous rk_ready: rk_valid is high for 11 consecutive cycles; done follows one cycle after the last key.
- Round transform next(): t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Only the MSB byte of the rotated, substituted word takes Rcon; the other three bytes pass unchanged.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00). The Rcon sequence is 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- start while busy: ignored, with no restart and no key recapture.
- key_in changes after the accepted start: no effect on the expansion.
- round_idx never exceeds 10 and never wraps.

Optional Feature:
- Macro AES_KEY_STORE_EN.
- Defined: an 11-entry register file captures each round key when it is handshaked. rd_key = entry[rd_idx], combinational read.
- Defined: entries with rd_idx>10, or entries not yet written since reset, read 0. This gives the decryption path reverse-order keys.
- Undefined: no storage is built; rd_key is tied 0 and rd_idx is unused.

Decomposition:
- Package aes_pkg: KEY_W, NUM_ROUNDS, RCON_INIT=8'h01, RCON_POLY=8'h1b, FSM state enum, S-box constant function.
- One sub-module, aes_key_round_step (combinational):
  - inputs: prev key, rcon.
  - output: next key.
  - internals: RotWord, 4 S-box lookups, Rcon XOR on the MSB byte, word-chain XOR.
- The controller owns the FSM, the rcon register, the round_idx counter and the optional store.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1: idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle after idx10.
- Same key, internal probe at round 1: t = 8b84eb01 (w3=09cf4f3c -> RotWord cf4f3c09 -> SubWord 8a84eb01 ^ 01000000). Expect 01,02,04,08,10,20,40,80,1b,36 across rounds 1..10.
- rk_ready toggled pseudo-randomly: same 11 keys in order, no drops or duplicates; round_key and round_idx stable while valid & !ready.
- start pulsed at idx 4 with a different key_in: ignored, and the sequence completes with the original key. rst_n low at idx 6: next cycle IDLE, rk_valid=0, busy=0, no done.
- Key all-zero: idx1 = 62636363626363636263636362636363 (SubWord(00)=63, ^01 gives 62).
- AES_KEY_STORE_EN defined, after the FIPS run: rd_idx=1 -> a0fafe17...7605; rd_idx=10 -> d014...0ca6; rd_idx=15 -> 0. Macro undefined: rd_key=0 for all rd_idx.
